// File: rtl/pulse_train_if.sv
// Command/status bundle between a pattern controller and pulse_train_gen.
interface pulse_train_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REP_W = 4
);
    logic [WIDTH-1:0] value;
    logic             load;
    logic [REP_W-1:0] reps;
    logic             msb_first;
    logic             stop;
    logic             pulse;
    logic             busy;
    logic             done;

    modport master (
        output value, load, reps, msb_first, stop,
        input  pulse, busy, done
    );

    modport slave (
        input  value, load, reps, msb_first, stop,
        output pulse, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Serialises a WIDTH-bit pattern (reps+1 passes) onto a registered pulse line with busy/done.
// Optional PULSE_TRAIN_GAP_EN inserts one idle-low cycle between consecutive passes.
module pulse_train_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REP_W = 4
) (
    input  logic          Clk,
    input  logic          Clr_n,
    pulse_train_if.slave  bus
);
    localparam int unsigned BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef PULSE_TRAIN_GAP_EN
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
`else
        ST_SHIFT = 2'd1
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sr_q, sr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [REP_W-1:0]    pcnt_q, pcnt_d;
    logic                dir_q, dir_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    sr_rot;
    logic                next_bit;

    // Rotation keeps the pattern intact so later passes replay it unchanged.
    assign sr_rot   = dir_q ? {sr_q[WIDTH-2:0], sr_q[WIDTH-1]} : {sr_q[0], sr_q[WIDTH-1:1]};
    assign next_bit = dir_q ? sr_rot[WIDTH-1] : sr_rot[0];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        pcnt_d  = pcnt_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;

        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        sr_d    = bus.value;
                        pcnt_d  = bus.reps;
                        dir_d   = bus.msb_first;
                        bcnt_d  = '0;
                        state_d = ST_SHIFT;
                        pulse_d = bus.msb_first ? bus.value[WIDTH-1] : bus.value[0];
                    end
                end
                ST_SHIFT: begin
                    sr_d = sr_rot;
                    if (bcnt_q != BCNT_LAST) begin
                        bcnt_d  = bcnt_q + BCNT_W'(1);
                        pulse_d = next_bit;
                    end else if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - REP_W'(1);
                        bcnt_d = '0;
`ifdef PULSE_TRAIN_GAP_EN
                        state_d = ST_GAP;
`else
                        pulse_d = next_bit;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef PULSE_TRAIN_GAP_EN
                // sr already holds the pattern realigned to its first bit.
                ST_GAP: begin
                    state_d = ST_SHIFT;
                    pulse_d = dir_q ? sr_q[WIDTH-1] : sr_q[0];
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            pcnt_q  <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule
